// File: rtl/pwr_steer_fifo.sv
// pwr_steer_fifo: per-channel operand steering into a DEPTH-entry FIFO with a
// registered head word and a saturating output-toggle counter for power studies.
module pwr_steer_fifo #(
   parameter int unsigned CH    = 17,
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                sel_hi,
   input  logic [1:0]          mode,
   input  logic [CH*W-1:0]     data_a,
   input  logic [CH*W-1:0]     data_b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*W-1:0]     out_data,
   input  logic                clr_cnt,
   output logic [CNT_W-1:0]    toggle_cnt,
   output logic                full,
   output logic                empty
);

   localparam int unsigned DW  = CH * W;
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW  = AW + 1;
   localparam int unsigned PCW = $clog2(DW + 1);
   localparam int unsigned SW  = ((CNT_W > PCW) ? CNT_W : PCW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   localparam logic [1:0] MODE_ZERO   = 2'b00;
   localparam logic [1:0] MODE_SELECT = 2'b01;
   localparam logic [1:0] MODE_MERGE  = 2'b10;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'b00,
      S_PARTIAL = 2'b01,
      S_FULL    = 2'b10
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DW-1:0]       r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW-1:0]       w_rd_nxt;
   logic [OW-1:0]       r_occ;
   logic [OW-1:0]       w_occ_nxt;
   logic [OW-1:0]       w_occ_after_pop;

   logic                r_in_ready;
   logic                r_out_valid;
   logic                r_full;
   logic                r_empty;
   logic [DW-1:0]       r_out_data;
   logic [DW-1:0]       w_head_nxt;
   logic [DW-1:0]       r_last_word;
   logic [DW-1:0]       r_last_pop;
   logic [CNT_W-1:0]    r_cnt;

   logic                w_push;
   logic                w_pop;
   logic [DW-1:0]       w_word;
   logic [DW-1:0]       w_diff;
   logic [PCW-1:0]      w_pc;
   logic [CNT_W-1:0]    w_base;
   logic [SW-1:0]       w_sum;
   logic                w_sat;

   assign in_ready   = r_in_ready;
   assign out_valid  = r_out_valid;
   assign full       = r_full;
   assign empty      = r_empty;
   assign out_data   = r_out_data;
   assign toggle_cnt = r_cnt;

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = r_out_valid & out_ready;

   // Steering function; all modes are bitwise so each channel slice is independent
   always_comb begin
      w_word = '0;
      case (mode)
         MODE_ZERO:   w_word = '0;
         MODE_SELECT: w_word = sel_hi ? data_b : data_a;
         MODE_MERGE:  w_word = data_a | data_b;
         default:     w_word = r_last_word;
      endcase
   end

   // Occupancy and read-pointer lookahead for the next cycle
   always_comb begin
      w_occ_nxt       = r_occ;
      w_occ_after_pop = r_occ - OW'(w_pop);
      w_rd_nxt        = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
      case ({w_push, w_pop})
         2'b10:   w_occ_nxt = r_occ + OW'(1);
         2'b01:   w_occ_nxt = r_occ - OW'(1);
         default: w_occ_nxt = r_occ;
      endcase
   end

   // Next head word: bypass the pushed word into an empty-after-pop FIFO, else hold when empty
   always_comb begin
      w_head_nxt = r_out_data;
      if (w_occ_nxt != '0) begin
         if (w_push && (w_occ_after_pop == '0)) begin
            w_head_nxt = w_word;
         end else begin
            w_head_nxt = r_mem[w_rd_nxt];
         end
      end
   end

   // Occupancy state next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: begin
            if (w_push) begin
               w_state_nxt = S_PARTIAL;
            end
         end
         S_PARTIAL: begin
            if (w_occ_nxt == OW'(DEPTH)) begin
               w_state_nxt = S_FULL;
            end else if (w_occ_nxt == '0) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            if (w_pop) begin
               w_state_nxt = S_PARTIAL;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // State register plus registered handshake/flag outputs decoded from next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_EMPTY;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_full      <= (w_state_nxt == S_FULL);
         r_empty     <= (w_state_nxt == S_EMPTY);
         r_in_ready  <= (w_state_nxt != S_FULL);
         r_out_valid <= (w_state_nxt != S_EMPTY);
      end
   end

   // Storage array; contents are don't-care outside the occupied window
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // Pointers, occupancy, head register and last pushed word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occ       <= '0;
         r_out_data  <= '0;
         r_last_word <= '0;
      end else begin
         r_rd_ptr   <= w_rd_nxt;
         r_occ      <= w_occ_nxt;
         r_out_data <= w_head_nxt;
         if (w_push) begin
            r_wr_ptr    <= r_wr_ptr + AW'(1);
            r_last_word <= w_word;
         end
      end
   end

   // Popcount of bit flips between this pop and the previous one
   always_comb begin
      w_diff = r_out_data ^ r_last_pop;
      w_pc   = '0;
      for (int unsigned i = 0; i < DW; i++) begin
         w_pc = w_pc + PCW'(w_diff[i]);
      end
   end

   // Saturating accumulate; a clear coinciding with a pop restarts from zero
   always_comb begin
      w_base = clr_cnt ? '0 : r_cnt;
      w_sum  = SW'(w_base) + SW'(w_pc);
      w_sat  = (w_sum > SW'(CNT_MAX));
   end

   // Toggle counter and last popped word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_last_pop <= '0;
      end else begin
         if (w_pop) begin
            r_cnt      <= w_sat ? CNT_MAX : CNT_W'(w_sum);
            r_last_pop <= r_out_data;
         end else if (clr_cnt) begin
            r_cnt <= '0;
         end
      end
   end

endmodule
